sprite_compositor: RTL and testbench

- Parametrised per-pixel colour generator for the VGA path.
- Composites NUM_SPRITES rectangular sprites over a background colour, in fixed priority order.
- Sprite geometry is double-buffered: it is latched once per frame, so there is no tearing.
- Adds a game-over flash/blank state machine and per-frame collision reporting against sprite 0 (the player).

---
 rtl/sprite_pkg.sv | 31 +++
 rtl/sprite_hit.sv | 34 +++
 rtl/sprite_compositor.sv | 199 +++++++++++++++++++
 tb/tb_sprite_compositor.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared types and colour constants for the sprite compositor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        FLASH = 2'd1,
        OVER  = 2'd2
    } state_e;

    localparam int C_RGB_CHAN_W = 8;

    typedef struct packed {
        logic [C_RGB_CHAN_W-1:0] r;
        logic [C_RGB_CHAN_W-1:0] g;
        logic [C_RGB_CHAN_W-1:0] b;
    } rgb_t;

    localparam rgb_t C_BLACK        = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t C_LAVA_RED     = '{r: 8'hCF, g: 8'h10, b: 8'h20};
    localparam rgb_t C_PLAYER_BLUE  = '{r: 8'h00, g: 8'h40, b: 8'hFF};
    localparam rgb_t C_LIFE_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};

endpackage

`default_nettype wire

// File: rtl/sprite_hit.sv
// ============================================================================
//  Module      : sprite_hit
//  Description : Bounds comparator for one rectangular sprite (clips, never wraps).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_hit #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_sx,
    input  logic [COORD_W-1:0] i_sy,
    input  logic [COORD_W-1:0] i_w,
    input  logic [COORD_W-1:0] i_h,
    input  logic               i_en,
    output logic               o_hit
);

    // One extra bit keeps the far edge exact so sprites past the screen edge clip.
    logic [COORD_W:0] w_xend;
    logic [COORD_W:0] w_yend;

    assign w_xend = {1'b0, i_sx} + {1'b0, i_w};
    assign w_yend = {1'b0, i_sy} + {1'b0, i_h};

    assign o_hit = i_en
                && (i_x >= i_sx) && ({1'b0, i_x} < w_xend)
                && (i_y >= i_sy) && ({1'b0, i_y} < w_yend);

endmodule

`default_nettype wire

// File: rtl/sprite_compositor.sv
// ============================================================================
//  Module      : sprite_compositor
//  Description : Two-stage sprite compositor with frame-latched geometry, game-over
//                flash FSM and optional player collision reporting (SPRITE_COLLISION_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES  = 8,
    parameter int COORD_W      = 10,
    parameter int COLOR_W      = 8,
    parameter int FLASH_FRAMES = 30
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           bright,
    input  logic [COORD_W-1:0]             x,
    input  logic [COORD_W-1:0]             y,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_w,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_h,
    input  logic [NUM_SPRITES*3*COLOR_W-1:0] sprite_color,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [3*COLOR_W-1:0]           bg_color,
    input  logic [3*COLOR_W-1:0]           flash_color,
    input  logic                           game_over,
    output logic [COLOR_W-1:0]             red,
    output logic [COLOR_W-1:0]             green,
    output logic [COLOR_W-1:0]             blue,
    output logic                           over_done,
    output logic [NUM_SPRITES-1:0]         collide_mask,
    output logic                           collide_valid
);

    localparam int C_RGB_W = 3 * COLOR_W;
    localparam int C_CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic [NUM_SPRITES*COORD_W-1:0] r_sx, r_sy, r_sw, r_sh;
    logic [NUM_SPRITES*C_RGB_W-1:0] r_col;
    logic [NUM_SPRITES-1:0]         r_en;
    logic [C_RGB_W-1:0]             r_bg, r_flash;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sx    <= '0;
            r_sy    <= '0;
            r_sw    <= '0;
            r_sh    <= '0;
            r_col   <= '0;
            r_en    <= '0;
            r_bg    <= '0;
            r_flash <= '0;
        end else if (frame_start) begin
            r_sx    <= sprite_x;
            r_sy    <= sprite_y;
            r_sw    <= sprite_w;
            r_sh    <= sprite_h;
            r_col   <= sprite_color;
            r_en    <= sprite_en;
            r_bg    <= bg_color;
            r_flash <= flash_color;
        end
    end

    logic [NUM_SPRITES-1:0] w_hit;

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
        sprite_hit #(
            .COORD_W (COORD_W)
        ) u_hit (
            .i_x   (x),
            .i_y   (y),
            .i_sx  (r_sx[gi*COORD_W +: COORD_W]),
            .i_sy  (r_sy[gi*COORD_W +: COORD_W]),
            .i_w   (r_sw[gi*COORD_W +: COORD_W]),
            .i_h   (r_sh[gi*COORD_W +: COORD_W]),
            .i_en  (r_en[gi]),
            .o_hit (w_hit[gi])
        );
    end

    state_e             r_state, w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PLAY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // game_over only matters at frame boundaries so the flash spans whole frames.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (frame_start) begin
            case (r_state)
                PLAY: begin
                    if (game_over) begin
                        w_state_nxt = FLASH;
                        w_cnt_nxt   = '0;
                    end
                end
                FLASH: begin
                    if (!game_over)
                        w_state_nxt = PLAY;
                    else if (r_cnt == C_CNT_W'(FLASH_FRAMES - 1))
                        w_state_nxt = OVER;
                    else
                        w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
                default: begin
                    if (!game_over)
                        w_state_nxt = PLAY;
                end
            endcase
        end
    end

    logic [NUM_SPRITES-1:0] r_hit;
    logic                   r_bright;
    logic [C_RGB_W-1:0]     r_rgb, w_pix, w_rgb;

    always_comb begin
        w_pix = r_bg;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (r_hit[i])
                w_pix = r_col[i*C_RGB_W +: C_RGB_W];
        end
        w_rgb = '0;
        if (r_bright) begin
            case (r_state)
                PLAY:    w_rgb = w_pix;
                FLASH:   w_rgb = r_flash;
                default: w_rgb = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit    <= '0;
            r_bright <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_hit    <= w_hit;
            r_bright <= bright;
            r_rgb    <= w_rgb;
        end
    end

    assign red       = r_rgb[3*COLOR_W-1 -: COLOR_W];
    assign green     = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign blue      = r_rgb[COLOR_W-1   -: COLOR_W];
    assign over_done = (r_state == OVER);

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] r_sticky, r_mask, w_coll;
    logic                   r_cvalid;

    always_comb begin
        w_coll = '0;
        if (bright && w_hit[0] && (r_state == PLAY))
            w_coll = {w_hit[NUM_SPRITES-1:1], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky <= '0;
            r_mask   <= '0;
            r_cvalid <= 1'b0;
        end else if (frame_start) begin
            r_mask   <= r_sticky;
            r_cvalid <= |r_sticky;
            r_sticky <= w_coll;
        end else begin
            r_sticky <= r_sticky | w_coll;
            r_cvalid <= 1'b0;
        end
    end

    assign collide_mask  = r_mask;
    assign collide_valid = r_cvalid;
`else
    assign collide_mask  = '0;
    assign collide_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
// ============================================================================
//  Module      : tb_sprite_compositor
//  Description : Self-checking bench for sprite_compositor against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_compositor;

    localparam int NS = 8;
    localparam int CW = 10;
    localparam int KW = 8;
    localparam int FF = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic              bright = 1'b0;
    logic [CW-1:0]     x = '0, y = '0;
    logic [NS*CW-1:0]  sprite_x, sprite_y, sprite_w, sprite_h;
    logic [NS*3*KW-1:0] sprite_color;
    logic [NS-1:0]     sprite_en;
    logic [3*KW-1:0]   bg_color = '0, flash_color = '0;
    logic              game_over = 1'b0;
    logic [KW-1:0]     red, green, blue;
    logic              over_done;
    logic [NS-1:0]     collide_mask;
    logic              collide_valid;

    sprite_compositor #(
        .NUM_SPRITES  (NS),
        .COORD_W      (CW),
        .COLOR_W      (KW),
        .FLASH_FRAMES (FF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .bright        (bright),
        .x             (x),
        .y             (y),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .sprite_w      (sprite_w),
        .sprite_h      (sprite_h),
        .sprite_color  (sprite_color),
        .sprite_en     (sprite_en),
        .bg_color      (bg_color),
        .flash_color   (flash_color),
        .game_over     (game_over),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .over_done     (over_done),
        .collide_mask  (collide_mask),
        .collide_valid (collide_valid)
    );

    always #5 clk = ~clk;

    int          in_sx[NS], in_sy[NS], in_sw[NS], in_sh[NS];
    logic [23:0] in_col[NS];
    bit          in_en[NS];

    always_comb begin
        sprite_x = '0; sprite_y = '0; sprite_w = '0; sprite_h = '0;
        sprite_color = '0; sprite_en = '0;
        for (int i = 0; i < NS; i++) begin
            sprite_x[i*CW +: CW]     = CW'(in_sx[i]);
            sprite_y[i*CW +: CW]     = CW'(in_sy[i]);
            sprite_w[i*CW +: CW]     = CW'(in_sw[i]);
            sprite_h[i*CW +: CW]     = CW'(in_sh[i]);
            sprite_color[i*24 +: 24] = in_col[i];
            sprite_en[i]             = in_en[i];
        end
    end

    // Frame-level model: latched scene, frames elapsed since game over, collision sets.
    int          m_sx[NS], m_sy[NS], m_sw[NS], m_sh[NS];
    logic [23:0] m_col[NS];
    bit          m_en[NS];
    logic [23:0] m_bg = '0, m_flash = '0;
    int          m_go = 0;
    logic [7:0]  m_sticky = '0, m_mask = '0;
    bit          m_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [23:0] cur_exp = '0, p1 = '0, p2 = '0;
    bit          p1v = 1'b0, p2v = 1'b0;

    function automatic logic [7:0] model_hits(input int px, input int py);
        logic [7:0] h = '0;
        for (int i = 0; i < NS; i++)
            h[i] = m_en[i] && px >= m_sx[i] && px < m_sx[i] + m_sw[i]
                           && py >= m_sy[i] && py < m_sy[i] + m_sh[i];
        return h;
    endfunction

    function automatic logic [23:0] model_pix(input int px, input int py, input bit br);
        logic [7:0] h;
        if (!br || m_go > FF) return 24'h0;
        if (m_go > 0) return m_flash;
        h = model_hits(px, py);
        for (int i = 0; i < NS; i++)
            if (h[i]) return m_col[i];
        return m_bg;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit fs, input bit br, input int px, input int py);
        logic [7:0] h, c;
        frame_start = fs;
        bright      = br;
        x           = CW'(px);
        y           = CW'(py);
        cur_exp     = model_pix(px, py, br);
        h           = model_hits(px, py);
        c           = (br && m_go == 0 && h[0]) ? (h & 8'hFE) : 8'h00;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                m_sx[i] = 0; m_sy[i] = 0; m_sw[i] = 0; m_sh[i] = 0;
                m_col[i] = '0; m_en[i] = 1'b0;
            end
            m_bg = '0; m_flash = '0; m_go = 0;
            m_sticky = '0; m_mask = '0; m_valid = 1'b0;
        end else if (fs) begin
            m_mask   = m_sticky;
            m_valid  = (m_sticky != 8'h00);
            m_sticky = c;
            for (int i = 0; i < NS; i++) begin
                m_sx[i] = in_sx[i]; m_sy[i] = in_sy[i];
                m_sw[i] = in_sw[i]; m_sh[i] = in_sh[i];
                m_col[i] = in_col[i]; m_en[i] = in_en[i];
            end
            m_bg    = bg_color;
            m_flash = flash_color;
            m_go    = game_over ? ((m_go > FF) ? FF + 1 : m_go + 1) : 0;
        end else begin
            m_sticky = m_sticky | c;
            m_valid  = 1'b0;
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            p1 <= '0; p2 <= '0; p1v <= 1'b1; p2v <= 1'b1;
        end else begin
            p1 <= cur_exp; p1v <= 1'b1;
            p2 <= p1;      p2v <= p1v;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (p2v) cmp("rgb_model", {8'h0, red, green, blue}, {8'h0, p2});
            cmp("over_done_model", {31'h0, over_done}, {31'h0, (m_go > FF)});
`ifdef SPRITE_COLLISION_EN
            cmp("collide_mask_model", {24'h0, collide_mask}, {24'h0, m_mask});
            cmp("collide_valid_model", {31'h0, collide_valid}, {31'h0, m_valid});
`else
            cmp("collide_mask_tied", {24'h0, collide_mask}, 32'h0);
            cmp("collide_valid_tied", {31'h0, collide_valid}, 32'h0);
`endif
        end
    end

    task automatic idle();
        step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic probe(input string name, input int px, input int py, input logic [23:0] lit);
        step(1'b0, 1'b1, px, py);
        idle();
        cmp(name, {8'h0, red, green, blue}, {8'h0, lit});
    endtask

    task automatic frame();
        idle();
        step(1'b1, 1'b0, 0, 0);
        idle();
    endtask

    task automatic sweep(input int py, input int x0, input int x1);
        for (int i = x0; i <= x1; i++) step(1'b0, 1'b1, i, py);
        idle();
    endtask

`ifdef SPRITE_COLLISION_EN
    localparam logic [7:0] C_EXP_MASK  = 8'h04;
    localparam logic       C_EXP_VALID = 1'b1;
`else
    localparam logic [7:0] C_EXP_MASK  = 8'h00;
    localparam logic       C_EXP_VALID = 1'b0;
`endif

    localparam logic [23:0] BLUE_C  = 24'h0000FF;
    localparam logic [23:0] GREEN_C = 24'h00FF00;
    localparam logic [23:0] BG_C    = 24'h202020;
    localparam logic [23:0] FLASH_C = 24'hFFFF00;
    localparam logic [23:0] CLIP_C  = 24'h123456;

    initial begin
        for (int i = 0; i < NS; i++) begin
            in_sx[i] = 0; in_sy[i] = 0; in_sw[i] = 0; in_sh[i] = 0;
            in_col[i] = '0; in_en[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) idle();
        reset  = 1'b0;
        chk_en = 1'b1;
        cmp("reset_rgb", {8'h0, red, green, blue}, 32'h0);
        cmp("reset_over_done", {31'h0, over_done}, 32'h0);
        cmp("reset_mask", {24'h0, collide_mask}, 32'h0);

        // Priority
        bg_color = BG_C; flash_color = FLASH_C;
        in_sx[0] = 100; in_sy[0] = 100; in_sw[0] = 16; in_sh[0] = 16; in_col[0] = BLUE_C;  in_en[0] = 1;
        in_sx[1] = 104; in_sy[1] = 104; in_sw[1] = 16; in_sh[1] = 16; in_col[1] = GREEN_C; in_en[1] = 1;
        probe("pre_frame_blank", 110, 110, 24'h0);
        frame();
        probe("prio_110", 110, 110, BLUE_C);
        probe("prio_118", 118, 118, GREEN_C);
        probe("prio_bg", 50, 50, BG_C);
        probe("edge_in", 115, 115, BLUE_C);
        probe("edge_out", 116, 102, BG_C);

        // Double buffer
        in_sx[0] = 200;
        probe("dbuf_old", 105, 102, BLUE_C);
        frame();
        probe("dbuf_vacated", 105, 102, BG_C);
        probe("dbuf_new", 205, 102, BLUE_C);

        // Clip at right edge
        in_sx[3] = 1020; in_sy[3] = 300; in_sw[3] = 16; in_sh[3] = 8; in_col[3] = CLIP_C; in_en[3] = 1;
        frame();
        probe("clip_1020", 1020, 300, CLIP_C);
        probe("clip_1023", 1023, 300, CLIP_C);
        probe("clip_no_wrap0", 0, 300, BG_C);
        probe("clip_no_wrap11", 11, 300, BG_C);

        // Collision with sprite 2 at a single pixel (215,115)
        in_sx[2] = 215; in_sy[2] = 115; in_sw[2] = 8; in_sh[2] = 8; in_col[2] = 24'hFF8000; in_en[2] = 1;
        frame();
        sweep(115, 208, 222);
        in_sx[2] = 400;
        idle();
        step(1'b1, 1'b0, 0, 0);
        cmp("coll_mask", {24'h0, collide_mask}, {24'h0, C_EXP_MASK});
        cmp("coll_valid", {31'h0, collide_valid}, {31'h0, C_EXP_VALID});
        idle();
        cmp("coll_valid_once", {31'h0, collide_valid}, 32'h0);
        sweep(115, 208, 222);
        idle();
        step(1'b1, 1'b0, 0, 0);
        cmp("coll_clear_mask", {24'h0, collide_mask}, 32'h0);
        cmp("coll_clear_valid", {31'h0, collide_valid}, 32'h0);
        idle();

        // Game over: three flash frames then OVER
        game_over = 1'b1;
        frame();
        probe("flash_f1", 205, 102, FLASH_C);
        cmp("flash_not_over", {31'h0, over_done}, 32'h0);
        frame();
        probe("flash_f2", 205, 102, FLASH_C);
        frame();
        probe("flash_f3", 205, 102, FLASH_C);
        frame();
        probe("over_black", 205, 102, 24'h0);
        cmp("over_done_hi", {31'h0, over_done}, 32'h1);
        game_over = 1'b0;
        frame();
        probe("back_to_play", 205, 102, BLUE_C);

        // Reset mid-frame while flashing
        game_over = 1'b1;
        frame();
        probe("flash_pre_reset", 205, 102, FLASH_C);
        step(1'b0, 1'b1, 205, 102);
        reset = 1'b1;
        step(1'b0, 1'b1, 205, 102);
        cmp("reset_mid_black", {8'h0, red, green, blue}, 32'h0);
        cmp("reset_mid_play", {31'h0, over_done}, 32'h0);
        reset = 1'b0;
        game_over = 1'b0;
        probe("reset_nothing_drawn", 205, 102, 24'h0);
        frame();
        probe("reset_redraw", 205, 102, BLUE_C);

        repeat (2) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
